multicycle_controller: RTL

Multicycle control unit for the MIPS-subset CPU, successor to the single-cycle controller. Sequences each instruction through fetch, decode, execute, memory and write-back states, drives the shared-datapath control lines, and handshakes with a variable-latency memory port. Adds a configurable memory-timeout watchdog, illegal-instruction detection and a retire pulse.

---
 rtl/mc_pkg.sv | 33 +++
 rtl/alu_ctrl_dec.sv | 34 +++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding, ALU control codes,
// opcode and funct values of the supported MIPS subset.
package mc_pkg;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StExeR, StExeI, StMemAddr, StMemRd, StMemWr,
    StWbAlu, StWbMem, StBranch, StJump, StFault
  } state_e;

  localparam logic [2:0] AluAddu = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluOr   = 3'b010;
  localparam logic [2:0] AluSubu = 3'b100;
  localparam logic [2:0] AluSub  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;
  localparam logic [2:0] AluSlt  = 3'b111;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from (op, funct); also flags whether an R-type funct
// is one the datapath supports.
module alu_ctrl_dec
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctr_o,
  output logic       funct_ok_o
);

  always_comb begin
    alu_ctr_o  = AluAddu;
    funct_ok_o = 1'b0;
    case (op_i)
      OpRtype: begin
        funct_ok_o = 1'b1;
        case (funct_i)
          FnAdd:   alu_ctr_o = AluAdd;
          FnAddu:  alu_ctr_o = AluAddu;
          FnSub:   alu_ctr_o = AluSub;
          FnSubu:  alu_ctr_o = AluSubu;
          FnSlt:   alu_ctr_o = AluSlt;
          FnSltu:  alu_ctr_o = AluSltu;
          default: funct_ok_o = 1'b0;
        endcase
      end
      OpOri:   alu_ctr_o = AluOr;
      OpBeq:   alu_ctr_o = AluSubu;
      default: alu_ctr_o = AluAddu;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: sequences each instruction through fetch/decode/execute/memory/
// write-back, drives datapath controls and guards memory waits with a timeout watchdog.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TIMEOUT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWr,
  output logic        PCWr,
  output logic        PCWrCond,
  output logic [1:0]  PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtOp,
  output logic [2:0]  ALUctr,
  output logic        RegWr,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [TIMEOUT_W-1:0] CntLimit = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [5:0]             op;
  logic [2:0]             dec_alu;
  logic                   funct_ok, ext_instr, in_wait, timeout_hit;
  logic                   unused_bits;

  assign op          = instr[31:26];
  assign unused_bits = ^{instr[25:6], zero};
  assign ext_instr   = (op == OpAddiu) || (op == OpLw) || (op == OpSw) || (op == OpBeq);
  assign in_wait     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // The access that would reach the limit still completes if mem_ready arrives that cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == CntLimit);

  alu_ctrl_dec u_alu_ctrl_dec (
    .op_i       (op),
    .funct_i    (instr[5:0]),
    .alu_ctr_o  (dec_alu),
    .funct_ok_o (funct_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRst;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StRst:    state_d = StFetch;
      StFetch, StMemRd, StMemWr: begin
        if (mem_ready) begin
          state_d = (state_q == StFetch) ? StDecode :
                    (state_q == StMemRd) ? StWbMem : StFetch;
        end else if (timeout_hit) begin
          state_d   = StFault;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        case (op)
          OpRtype:        state_d = funct_ok ? StExeR : StFault;
          OpOri, OpAddiu: state_d = StExeI;
          OpLw, OpSw:     state_d = StMemAddr;
          OpBeq:          state_d = StBranch;
          OpJ:            state_d = StJump;
          default:        state_d = StFault;
        endcase
        if (state_d == StFault) illegal_d = 1'b1;
      end
      StExeR, StExeI: state_d = StWbAlu;
      StMemAddr:      state_d = (op == OpSw) ? StMemWr : StMemRd;
      StWbAlu, StWbMem, StBranch, StJump: state_d = StFetch;
      StFault:        state_d = StFault;
      default:        state_d = StFault;
    endcase

    wait_cnt_d = '0;
    if (in_wait && !mem_ready && (state_d == state_q)) begin
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCWrCond = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b0;
    ALUctr   = AluAddu;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        ExtOp   = ext_instr;
      end
      StExeR: begin
        ALUSrcA = 1'b1;
        ALUctr  = dec_alu;
      end
      StExeI, StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = ext_instr;
        ALUctr  = dec_alu;
      end
      StMemRd: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        retire  = mem_ready;
      end
      StWbAlu: begin
        RegWr  = 1'b1;
        RegDst = (op == OpRtype);
        retire = 1'b1;
      end
      StWbMem: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        PCWrCond = 1'b1;
        PCSrc    = 2'b01;
        ExtOp    = ext_instr;
        ALUctr   = dec_alu;
        retire   = 1'b1;
      end
      StJump: begin
        PCWr   = 1'b1;
        PCSrc  = 2'b10;
        retire = 1'b1;
      end
      StRst, StFault: ;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
